// File: rtl/sdram_wb_arbiter.sv
// Two-master pipelined Wishbone arbiter in front of the SDRAM controller slave port.
// Round-robin by default; define SDRAM_WB_ARB_FIXED_PRIO_EN to give m0 fixed priority.
module sdram_wb_arbiter #(
    parameter int DEPTH   = 8,
    parameter int DEPTH_W = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_data_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [2:0]  m0_cti_i,
    input  logic        m0_we_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    output logic [31:0] m0_data_o,
    output logic        m0_ack_o,
    output logic        m0_stall_o,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_data_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [2:0]  m1_cti_i,
    input  logic        m1_we_i,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    output logic [31:0] m1_data_o,
    output logic        m1_ack_o,
    output logic        m1_stall_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_data_o,
    output logic [3:0]  s_sel_o,
    output logic [2:0]  s_cti_o,
    output logic        s_we_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    input  logic [31:0] s_data_i,
    input  logic        s_ack_i,
    input  logic        s_stall_i
);

    localparam logic [2:0]       CTI_BURST = 3'b010;
    localparam logic [2:0]       CTI_END   = 3'b111;
    localparam logic [DEPTH_W:0] CNT_ONE   = 1;
    localparam logic [DEPTH_W:0] CNT_FULL  = (DEPTH_W+1)'(DEPTH);
    localparam logic [DEPTH_W-1:0] PTR_ONE = 1;

    logic req0, req1;
    logic grant, prev_grant;
    logic lock, owner, owner_cyc;
    logic ack_err;
`ifndef SDRAM_WB_ARB_FIXED_PRIO_EN
    logic last_grant;
`endif

    logic [DEPTH_W:0]   count;
    logic [DEPTH_W-1:0] wr_ptr, rd_ptr;
    logic               fifo_mem [DEPTH];
    logic               head;

    logic        full, stb, accept, ack_hit;
    logic [31:0] g_addr, g_data;
    logic [3:0]  g_sel;
    logic [2:0]  g_cti;
    logic        g_we;

    assign req0 = m0_cyc_i & m0_stb_i;
    assign req1 = m1_cyc_i & m1_stb_i;

    // With nobody requesting the grant parks on whoever had it last cycle.
    always_comb begin
        grant = prev_grant;
        if (lock)
            grant = owner;
        else if (req0 && req1)
`ifdef SDRAM_WB_ARB_FIXED_PRIO_EN
            grant = 1'b0;
`else
            grant = ~last_grant;
`endif
        else if (req0)
            grant = 1'b0;
        else if (req1)
            grant = 1'b1;
    end

    assign g_addr = grant ? m1_addr_i : m0_addr_i;
    assign g_data = grant ? m1_data_i : m0_data_i;
    assign g_sel  = grant ? m1_sel_i  : m0_sel_i;
    assign g_cti  = grant ? m1_cti_i  : m0_cti_i;
    assign g_we   = grant ? m1_we_i   : m0_we_i;

    assign full      = (count == CNT_FULL);
    assign stb       = (grant ? req1 : req0) & ~full;
    assign accept    = stb & ~s_stall_i;
    assign head      = fifo_mem[rd_ptr];
    assign ack_hit   = s_ack_i & (count != '0);
    assign owner_cyc = owner ? m1_cyc_i : m0_cyc_i;

    // Outputs are forced quiet (and both masters stalled) while reset is held.
    assign s_addr_o   = rst_i ? g_addr : '0;
    assign s_data_o   = rst_i ? g_data : '0;
    assign s_sel_o    = rst_i ? g_sel  : '0;
    assign s_cti_o    = rst_i ? g_cti  : '0;
    assign s_we_o     = rst_i & g_we;
    assign s_stb_o    = rst_i & stb;
    assign s_cyc_o    = rst_i & (stb | (count != '0) | lock);

    assign m0_stall_o = ~rst_i | grant  | s_stall_i | full;
    assign m1_stall_o = ~rst_i | ~grant | s_stall_i | full;
    assign m0_ack_o   = rst_i & ack_hit & ~head;
    assign m1_ack_o   = rst_i & ack_hit & head;
    assign m0_data_o  = rst_i ? s_data_i : '0;
    assign m1_data_o  = rst_i ? s_data_i : '0;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            lock       <= 1'b0;
            owner      <= 1'b0;
            prev_grant <= 1'b0;
            ack_err    <= 1'b0;
`ifndef SDRAM_WB_ARB_FIXED_PRIO_EN
            last_grant <= 1'b1;
`endif
        end else begin
            prev_grant <= grant;
            if (accept)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (ack_hit)
                rd_ptr <= rd_ptr + PTR_ONE;
            case ({accept, ack_hit})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (s_ack_i && (count == '0))
                ack_err <= 1'b1;
            // A locked owner cannot be accepted once its cyc drops, so abort and accept never collide.
            if (accept) begin
`ifndef SDRAM_WB_ARB_FIXED_PRIO_EN
                last_grant <= grant;
`endif
                if (g_cti == CTI_BURST) begin
                    lock  <= 1'b1;
                    owner <= grant;
                end else if (g_cti == CTI_END) begin
                    lock  <= 1'b0;
                end
            end else if (lock && !owner_cyc) begin
                lock <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept)
            fifo_mem[wr_ptr] <= grant;
    end

    a_ack_err_sticky: assert property (@(posedge clk_i) disable iff (!rst_i) ack_err |=> ack_err);

endmodule

// File: tb/tb_sdram_wb_arbiter.sv
// Randomized bench for sdram_wb_arbiter: per-cycle arbitration model plus end-to-end read-data scoreboard.
module tb_sdram_wb_arbiter;

    localparam int DEPTH = 8;

    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    logic [31:0] m_addr [2];
    logic [31:0] m_wdata [2];
    logic [3:0]  m_sel [2];
    logic [2:0]  m_cti [2];
    logic        m_we [2];
    logic        m_cyc [2];
    logic        m_stb [2];
    logic [31:0] m0_data_o, m1_data_o;
    logic        m0_ack_o, m1_ack_o, m0_stall_o, m1_stall_o;
    logic [31:0] s_addr_o, s_data_o, s_data_i;
    logic [3:0]  s_sel_o;
    logic [2:0]  s_cti_o;
    logic        s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_stall_i;

    sdram_wb_arbiter #(.DEPTH(DEPTH), .DEPTH_W(3)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_addr_i(m_addr[0]), .m0_data_i(m_wdata[0]), .m0_sel_i(m_sel[0]), .m0_cti_i(m_cti[0]),
        .m0_we_i(m_we[0]), .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]),
        .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o), .m0_stall_o(m0_stall_o),
        .m1_addr_i(m_addr[1]), .m1_data_i(m_wdata[1]), .m1_sel_i(m_sel[1]), .m1_cti_i(m_cti[1]),
        .m1_we_i(m_we[1]), .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]),
        .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o), .m1_stall_o(m1_stall_o),
        .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_sel_o(s_sel_o), .s_cti_o(s_cti_o),
        .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
        .s_data_i(s_data_i), .s_ack_i(s_ack_i), .s_stall_i(s_stall_i)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_n   = 0;
    int ack_pct, stall_pct, req_pct, abort_pct, spur_pct, gap_pct;
    int beats_left [2];
    int beats_done [2];

    // Reference model: ordered owner list, burst lock, last winner, parked grant.
    int oq[$];
    bit md_lock;
    int md_owner, md_last, md_prev;

    // Slave and master scoreboards.
    int          sq_due[$];
    logic [31:0] sq_addr[$];
    bit          sq_we[$];
    logic [32:0] mq0[$];
    logic [32:0] mq1[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc_n);
        end
    endtask

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic int mq_size(input int n);
        return (n == 0) ? mq0.size() : mq1.size();
    endfunction

    function automatic bit pct(input int p);
        return int'($urandom_range(99)) < p;
    endfunction

    task automatic master_ack(input int n, input logic [31:0] data);
        logic [32:0] e;
        if (mq_size(n) == 0) begin
            check(n == 0 ? "m0_ack_unowned" : "m1_ack_unowned", 32'd1, 32'd0);
            return;
        end
        e = (n == 0) ? mq0.pop_front() : mq1.pop_front();
        if (!e[32])
            check(n == 0 ? "m0_rdata" : "m1_rdata", data, rdata_of(e[31:0]));
    endtask

    task automatic gen_master(input int n, input bit acc_n);
        bit held;
        held = m_stb[n] && !acc_n;
        if (beats_done[n] > 0 && beats_left[n] > 0 && pct(abort_pct)) begin
            beats_left[n] = 0;
            beats_done[n] = 0;
            m_stb[n] = 1'b0;
            m_cyc[n] = 1'b0;
            return;
        end
        if (held) begin
            m_cyc[n] = 1'b1;
            return;
        end
        if (acc_n)
            m_addr[n] = m_addr[n] + 32'd4;
        if (beats_left[n] == 0) begin
            beats_done[n] = 0;
            if (pct(req_pct)) begin
                beats_left[n] = ($urandom_range(1) == 0) ? 1 : int'($urandom_range(2, 8));
                m_addr[n] = $urandom() & 32'hFFFF_FFFC;
                m_we[n]   = 1'($urandom_range(1));
                m_sel[n]  = 4'($urandom_range(15));
            end
        end
        if (beats_left[n] > 0) begin
            m_stb[n]   = (beats_done[n] == 0) || !pct(gap_pct);
            m_cti[n]   = (beats_left[n] == 1) ? 3'b111 : 3'b010;
            m_wdata[n] = $urandom();
        end else begin
            m_stb[n] = 1'b0;
        end
        m_cyc[n] = m_stb[n] || beats_left[n] > 0 || mq_size(n) != 0;
    endtask

    task automatic gen_slave();
        s_stall_i = pct(stall_pct);
        s_ack_i   = 1'b0;
        s_data_i  = $urandom();
        if (sq_due.size() > 0) begin
            if (sq_due[0] <= cyc_n && pct(ack_pct)) begin
                s_ack_i = 1'b1;
                if (!sq_we[0])
                    s_data_i = rdata_of(sq_addr[0]);
            end
        end else if (pct(spur_pct)) begin
            s_ack_i = 1'b1;
        end
    endtask

    task automatic cycle_step();
        bit r [2];
        int g;
        bit full, stb, acc, ea, own_cyc, we_g;
        logic [2:0]  cti_g;
        logic [31:0] a_g;
        @(negedge clk_i);
        r[0] = m_cyc[0] && m_stb[0];
        r[1] = m_cyc[1] && m_stb[1];
        if (md_lock)
            g = md_owner;
        else if (r[0] && r[1])
`ifdef SDRAM_WB_ARB_FIXED_PRIO_EN
            g = 0;
`else
            g = (md_last == 0) ? 1 : 0;
`endif
        else if (r[0])
            g = 0;
        else if (r[1])
            g = 1;
        else
            g = md_prev;
        full = oq.size() >= DEPTH;
        stb  = r[g] && !full;
        acc  = stb && !s_stall_i;
        ea   = s_ack_i && oq.size() > 0;

        check("s_stb", 32'(s_stb_o), 32'(stb));
        check("s_cyc", 32'(s_cyc_o), 32'(stb || oq.size() != 0 || md_lock));
        check("s_addr", s_addr_o, m_addr[g]);
        check("s_wdata", s_data_o, m_wdata[g]);
        check("s_ctl", 32'({s_we_o, s_cti_o, s_sel_o}), 32'({m_we[g], m_cti[g], m_sel[g]}));
        check("m0_stall", 32'(m0_stall_o), 32'(g != 0 || s_stall_i || full));
        check("m1_stall", 32'(m1_stall_o), 32'(g != 1 || s_stall_i || full));
        check("m0_ack", 32'(m0_ack_o), 32'(ea && oq[0] == 0));
        check("m1_ack", 32'(m1_ack_o), 32'(ea && oq[0] == 1));
        check("m0_data", m0_data_o, s_data_i);
        check("m1_data", m1_data_o, s_data_i);
        if (m0_ack_o) master_ack(0, m0_data_o);
        if (m1_ack_o) master_ack(1, m1_data_o);

        cti_g   = m_cti[g];
        a_g     = m_addr[g];
        we_g    = m_we[g];
        own_cyc = m_cyc[md_owner];
        @(posedge clk_i);
        #1;
        cyc_n++;
        if (ea) void'(oq.pop_front());
        if (s_ack_i && sq_due.size() > 0) begin
            void'(sq_due.pop_front());
            void'(sq_addr.pop_front());
            void'(sq_we.pop_front());
        end
        if (md_lock && !own_cyc)
            md_lock = 1'b0;
        if (acc) begin
            oq.push_back(g);
            md_last = g;
            if (cti_g == 3'b010) begin
                md_lock  = 1'b1;
                md_owner = g;
            end else if (cti_g == 3'b111) begin
                md_lock = 1'b0;
            end
            if (g == 0) mq0.push_back({we_g, a_g});
            else        mq1.push_back({we_g, a_g});
            beats_left[g]--;
            beats_done[g]++;
            sq_due.push_back(cyc_n + int'($urandom_range(0, 3)));
            sq_addr.push_back(a_g);
            sq_we.push_back(we_g);
        end
        md_prev = g;
        gen_master(0, acc && g == 0);
        gen_master(1, acc && g == 1);
        gen_slave();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_stb"}, 32'(s_stb_o), 32'd0);
        check({tag, "_s_cyc"}, 32'(s_cyc_o), 32'd0);
        check({tag, "_s_addr"}, s_addr_o, 32'd0);
        check({tag, "_s_wdata"}, s_data_o, 32'd0);
        check({tag, "_s_ctl"}, 32'({s_we_o, s_cti_o, s_sel_o}), 32'd0);
        check({tag, "_acks"}, 32'({m0_ack_o, m1_ack_o}), 32'd0);
        check({tag, "_stalls"}, 32'({m0_stall_o, m1_stall_o}), 32'b11);
        check({tag, "_mdata"}, m0_data_o | m1_data_o, 32'd0);
    endtask

    task automatic clear_model();
        oq.delete();
        sq_due.delete();
        sq_addr.delete();
        sq_we.delete();
        mq0.delete();
        mq1.delete();
        md_lock  = 1'b0;
        md_owner = 0;
        md_last  = 1;
        md_prev  = 0;
        for (int n = 0; n < 2; n++) begin
            beats_left[n] = 0;
            beats_done[n] = 0;
            m_stb[n] = 1'b0;
            m_cyc[n] = 1'b0;
        end
        s_ack_i = 1'b0;
    endtask

    task automatic set_phase(input int a, input int s, input int q, input int ab, input int sp, input int gp);
        ack_pct = a; stall_pct = s; req_pct = q; abort_pct = ab; spur_pct = sp; gap_pct = gp;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle_step();
    endtask

    initial begin
        rst_i = 1'b0;
        for (int n = 0; n < 2; n++) begin
            m_addr[n] = $urandom() | 32'h10; m_wdata[n] = $urandom(); m_sel[n] = 4'hF;
            m_cti[n] = 3'b111; m_we[n] = 1'b1; m_cyc[n] = 1'b1; m_stb[n] = 1'b1;
        end
        s_data_i = 32'hCAFE_0001; s_ack_i = 1'b1; s_stall_i = 1'b0;
        #3;
        check_reset_outputs("rst0");
        @(posedge clk_i);
        #1;
        check_reset_outputs("rst1");
        clear_model();
        @(negedge clk_i);
        rst_i = 1'b1;

        set_phase(70, 20, 60, 3, 5, 20);
        run(1500);
        set_phase(0, 0, 100, 0, 0, 20);
        run(60);
        set_phase(90, 10, 80, 2, 3, 10);
        run(1500);

        set_phase(100, 0, 0, 0, 0, 20);
        for (int i = 0; i < 600; i++) begin
            if (oq.size() == 0 && !md_lock && beats_left[0] == 0 && beats_left[1] == 0 &&
                !m_stb[0] && !m_stb[1])
                break;
            cycle_step();
        end
        s_ack_i = 1'b0;
        #1;
        check("drain_idle_cyc", 32'(s_cyc_o), 32'd0);

        // m1 starts an 8-beat write burst while m0 wants a single read; no acks so commands pile up.
        set_phase(0, 0, 0, 0, 0, 0);
        beats_left[1] = 8; beats_done[1] = 0; m_addr[1] = 32'h0000_1000; m_we[1] = 1'b1; m_sel[1] = 4'hF;
        beats_left[0] = 1; beats_done[0] = 0; m_addr[0] = 32'h0000_2000; m_we[0] = 1'b0; m_sel[0] = 4'hF;
        gen_master(0, 1'b0);
        gen_master(1, 1'b0);
        gen_slave();
        for (int i = 0; i < 20; i++) begin
            if (oq.size() >= 3 && md_lock) break;
            cycle_step();
        end
        check("pre_reset_cyc", 32'(s_cyc_o), 32'd1);

        s_ack_i = 1'b1;
        s_data_i = 32'hDEAD_BEEF;
        #2 rst_i = 1'b0;
        #1;
        check_reset_outputs("rst_mid0");
        @(posedge clk_i);
        #1;
        check_reset_outputs("rst_mid1");
        clear_model();
        @(negedge clk_i);
        rst_i = 1'b1;

        set_phase(0, 0, 0, 0, 100, 0);
        gen_slave();
        run(5);
        set_phase(80, 15, 60, 2, 3, 20);
        run(300);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_wb_arbiter.md
Name: sdram_wb_arbiter

Overview:
Two-port pipelined Wishbone arbiter that shares the SDRAM controller's single Wishbone slave port between two masters (e.g. CPU and DMA).
- Arbitration is round-robin.
- Bursts (cti=010 … 111) are never interleaved.
- An ordered owner FIFO routes each ack back to the master that issued the command, so multiple commands can be outstanding across grant changes.

Parameters:
- DEPTH, 8, maximum outstanding accepted-but-unacked commands (power of 2, ≥2).
- DEPTH_W, 3, log2(DEPTH).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-low
- mN_addr_i  in  32  master N address (N=0,1; all mN_* ports exist for both masters)
- mN_data_i  in  32  master N write data
- mN_sel_i  in  4  byte enables
- mN_cti_i  in  3  cycle type (111 single/last, 010 burst continue)
- mN_we_i  in  1  write enable
- mN_cyc_i  in  1  cycle
- mN_stb_i  in  1  strobe
- mN_data_o  out  32  read data (s_data_i broadcast)
- mN_ack_o  out  1  ack
- mN_stall_o  out  1  stall
- s_addr_o / s_data_o / s_sel_o / s_cti_o / s_we_o  out  32/32/4/3/1  muxed command to SDRAM controller
- s_cyc_o  out  1  cycle
- s_stb_o  out  1  strobe
- s_data_i  in  32  read data
- s_ack_i  in  1  ack
- s_stall_i  in  1  stall

Behaviour:
- Reset (rst_i=0, async):
  - Owner FIFO count=0, lock=0, owner=0, last_grant=1 (m0 wins first).
  - All outputs 0, except mN_stall_o=1 while reset is asserted.
- Request: reqN = mN_cyc_i & mN_stb_i.
- Grant is combinational from registered state:
  - lock=1: grant=owner.
  - lock=0 and both requesting: grant = !last_grant.
  - lock=0 and one requesting: grant = that master.
  - lock=0 and none requesting: grant holds its previous value, but s_stb_o=0.
- Command path:
  - s_addr/data/sel/cti/we = granted master's inputs.
  - s_stb_o = req[grant] & !full.
  - full = (count==DEPTH).
- Stall:
  - mN_stall_o = 1 if N≠grant.
  - Otherwise mN_stall_o = s_stall_i | full.
  - A non-requesting master sees stall=1 unless granted.
- Accept = s_stb_o & !s_stall_i. On accept:
  - Push grant ID into owner FIFO.
  - last_grant <= grant.
  - If cti==010: lock <= 1, owner <= grant.
  - If cti==111: lock <= 0.
- Burst abort: if lock=1 and mN_cyc_i of the owner drops, lock <= 0 next cycle. Outstanding FIFO entries are still honoured.
- Ack routing:
  - On s_ack_i: m[fifo_head]_ack_o = 1 in the same cycle (combinational), then pop.
  - mN_data_o = s_data_i for both masters; only the acked master samples it.
- Simultaneous accept and ack in one cycle: push and pop both occur, count unchanged. Push is never blocked by a same-cycle pop; full is evaluated on the registered count.
- Ack with count==0: discarded, no mN_ack_o asserted, and the sticky ack_err flag (internal) is set.
- s_cyc_o = s_stb_o | (count!=0) | lock.
- Latency: zero added cycles on the command path and the ack path.
- FIFO: pointers are DEPTH_W bits and wrap modulo DEPTH; count is DEPTH_W+1 bits.
- Reset mid-operation: FIFO flushed, lock cleared; acks arriving after reset are treated as count==0 acks.

Optional Feature:
- Macro: SDRAM_WB_ARB_FIXED_PRIO_EN.
- Defined: m0 always wins when lock=0 and both request; last_grant is unused.
- Undefined: round-robin as above. Burst lock applies in both modes.

Test Plan:
- Both masters issue single writes continuously, s_stall_i=0, ack 2 cycles later → accepted order m0,m1,m0,m1…; every mN_ack_o goes only to its issuer.
- m1 issues 8-beat burst (7×cti=010, last cti=111), m0 requesting throughout → all 8 beats from m1 consecutive on s_*, m0 stall=1 until the cti=111 beat is accepted, then m0 granted next cycle.
- Hold s_ack_i=0, both masters request 10 singles → exactly 8 accepts, then both stall=1 and s_stb_o=0; one ack → one new accept in the next cycle.
- m0 read at 0x100, m1 read at 0x200 back-to-back, slave acks in order with data 0xA, 0xB → m0 gets ack+0xA, then m1 gets ack+0xB.
- Assert rst_i=0 with 3 commands outstanding and lock=1 → outputs zero, count=0; a subsequent s_ack_i produces no mN_ack_o.
- With SDRAM_WB_ARB_FIXED_PRIO_EN defined, both masters request singles continuously → m0 wins every arbitration, m1 never accepted.
